gate_checker: RTL and testbench

GATE_CHECKER -- requirements
Module: gate_checker

---
 rtl/gate_chk_pkg.sv | 16 +
 rtl/gate_ref_model.sv | 14 +
 rtl/gate_checker.sv | 146 ++++++++++++++
 tb/tb_gate_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the combinational gate checker.
// Holds the checker FSM state encoding and the last stimulus pattern index.
// No logic; imported by the checker top.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Final pattern of the exhaustive {a,b,c} sweep.
    localparam logic [2:0] PAT_LAST = 3'd7;

endpackage

// File: rtl/gate_ref_model.sv
// Golden NAND/NOT reference: expected gate outputs for the current {a,b,c} pattern.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows pat continuously.
module gate_ref_model (
    input  logic [2:0] pat,
    output logic       exp_nand,
    output logic       exp_not
);

    // pat is {a,b,c}: a and b feed the NAND, c feeds the NOT.
    assign exp_nand = ~(pat[2] & pat[1]);
    assign exp_not  = ~pat[0];

endmodule

// File: rtl/gate_checker.sv
// Exhaustive NAND/NOT gate checker: sweeps all 8 {a,b,c} patterns, counts mismatches.
// Latency: each pattern takes SETTLE_CYCLES+1 cycles; done rises 8*(SETTLE_CYCLES+1)+1 cycles after start.
// Backpressure: start is ignored while busy; results hold in DONE until the next start or reset.
module gate_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    input  logic             nand_i,
    input  logic             not_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       fail_pat,
    output logic             fail_vld
);

    // Counter reload value: SETTLE cycles spent counting down to and including zero.
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           state_q,    state_d;
    logic [2:0]       pat_q,      pat_d;
    logic [7:0]       cnt_q,      cnt_d;
    logic [ERR_W-1:0] err_q,      err_d;
    logic [2:0]       fail_pat_q, fail_pat_d;
    logic             fail_vld_q, fail_vld_d;
    logic             done_q,     done_d;
    logic             busy_q,     busy_d;
    logic             pass_q,     pass_d;

    logic             exp_nand;
    logic             exp_not;
    logic             mismatch;

    gate_ref_model u_ref (
        .pat      (pat_q),
        .exp_nand (exp_nand),
        .exp_not  (exp_not)
    );

    assign mismatch = (nand_i != exp_nand) || (not_i != exp_not);

    // Next-state and next-register computation for the sweep FSM.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        fail_pat_d = fail_pat_q;
        fail_vld_d = fail_vld_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pat_d      = 3'd0;
                    err_d      = '0;
                    fail_vld_d = 1'b0;
                    cnt_d      = SETTLE_LOAD;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    // Only the first failing pattern of a run is captured.
                    if (!fail_vld_q) begin
                        fail_pat_d = pat_q;
                        fail_vld_d = 1'b1;
                    end
                end
                if (pat_q == PAT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    pat_d   = pat_q + 3'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they register alongside it;
    // pass sees the final sample's error update in the same cycle done rises.
    always_comb begin
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        pass_d = done_d && (err_d == '0);
    end

    // Single register bank for FSM state, sweep datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pat_q      <= 3'd0;
            cnt_q      <= 8'd0;
            err_q      <= '0;
            fail_pat_q <= 3'd0;
            fail_vld_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            fail_pat_q <= fail_pat_d;
            fail_vld_q <= fail_vld_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
        end
    end

    assign a_o      = pat_q[2];
    assign b_o      = pat_q[1];
    assign c_o      = pat_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_pat = fail_pat_q;
    assign fail_vld = fail_vld_q;

endmodule

// File: tb/tb_gate_checker.sv
// Randomized scoreboard bench for gate_checker with a fault-injectable gate under test.
// Two checker instances (ERR_W=8 and ERR_W=2) observe the same faulty gate behaviour.
// A monitor pops expected run results whenever done rises and compares them.
module tb_gate_checker;

    localparam int SC       = 4;
    localparam int DONE_CYC = 8 * (SC + 1) + 1;

    typedef struct {
        int         err;
        logic [2:0] fpat;
        logic       fvld;
        logic       pass;
        int         start_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] nand_mask;
    logic [7:0] not_mask;
    int         cyc = 0;

    logic       a8, b8, c8, nand8, not8, busy8, done8, pass8, fvld8;
    logic [7:0] err8;
    logic [2:0] fpat8;
    logic       a2, b2, c2, nand2, not2, busy2, done2, pass2, fvld2;
    logic [1:0] err2;
    logic [2:0] fpat2;

    exp_t q8[$];
    exp_t q2[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test: correct NAND/NOT, with per-pattern output inversion faults.
    assign nand8 = ~(a8 & b8) ^ nand_mask[{a8, b8, c8}];
    assign not8  = ~c8        ^ not_mask[{a8, b8, c8}];
    assign nand2 = ~(a2 & b2) ^ nand_mask[{a2, b2, c2}];
    assign not2  = ~c2        ^ not_mask[{a2, b2, c2}];

    gate_checker #(.SETTLE_CYCLES(SC), .ERR_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a8), .b_o(b8), .c_o(c8),
        .nand_i(nand8), .not_i(not8),
        .busy(busy8), .done(done8), .pass(pass8),
        .err_cnt(err8), .fail_pat(fpat8), .fail_vld(fvld8)
    );

    gate_checker #(.SETTLE_CYCLES(SC), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a2), .b_o(b2), .c_o(c2),
        .nand_i(nand2), .not_i(not2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_pat(fpat2), .fail_vld(fvld2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk all 8 patterns; a pattern fails if either gate output is faulted.
    function automatic exp_t model(input logic [7:0] nm, input logic [7:0] tm,
                                   input int w, input int sc);
        exp_t e;
        e.err       = 0;
        e.fpat      = 3'd0;
        e.fvld      = 1'b0;
        e.start_cyc = sc;
        for (int p = 0; p < 8; p++) begin
            if (nm[p] || tm[p]) begin
                if (e.err < (1 << w) - 1) e.err++;
                if (!e.fvld) begin
                    e.fvld = 1'b1;
                    e.fpat = 3'(p);
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    // Monitor: on each rising done, pop the expected result and compare.
    logic done8_prev = 1'b0;
    logic done2_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done8 && !done8_prev) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 1, 0);
            end else begin
                e = q8.pop_front();
                check("done_cycle8", cyc - e.start_cyc, DONE_CYC);
                check("err_cnt8", int'(err8), e.err);
                check("fail_vld8", int'(fvld8), int'(e.fvld));
                check("pass8", int'(pass8), int'(e.pass));
                check("busy_at_done8", int'(busy8), 0);
                if (e.fvld) check("fail_pat8", int'(fpat8), int'(e.fpat));
            end
        end
        if (done2 && !done2_prev) begin
            if (q2.size() == 0) begin
                check("unexpected_done2", 1, 0);
            end else begin
                e = q2.pop_front();
                check("done_cycle2", cyc - e.start_cyc, DONE_CYC);
                check("err_cnt2_sat", int'(err2), e.err);
                check("fail_vld2", int'(fvld2), int'(e.fvld));
                check("pass2", int'(pass2), int'(e.pass));
                if (e.fvld) check("fail_pat2", int'(fpat2), int'(e.fpat));
            end
        end
        done8_prev = done8;
        done2_prev = done2;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     int'(busy8 | busy2), 0);
        check({tag, "_done"},     int'(done8 | done2), 0);
        check({tag, "_pass"},     int'(pass8 | pass2), 0);
        check({tag, "_err_cnt"},  int'(err8) + int'(err2), 0);
        check({tag, "_fail_pat"}, int'(fpat8 | fpat2), 0);
        check({tag, "_fail_vld"}, int'(fvld8 | fvld2), 0);
        check({tag, "_pat"},      int'({a8, b8, c8} | {a2, b2, c2}), 0);
    endtask

    // Full run; optional repulse of start at cycle 10; optional reset at cycle 20.
    task automatic run(input logic [7:0] nm, input logic [7:0] tm,
                       input bit repulse, input bit abort);
        int sc;
        int n;
        nand_mask = nm;
        not_mask  = tm;
        @(negedge clk);
        start = 1'b1;
        sc    = cyc;
        if (!abort) begin
            q8.push_back(model(nm, tm, 8, sc));
            q2.push_back(model(nm, tm, 2, sc));
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy8), 1);
        check("done_clear_after_start", int'(done8), 0);
        check("pat_after_start", int'({a8, b8, c8}), 0);
        while (cyc < sc + 6) @(negedge clk);
        check("pat_after_first_sample", int'({a8, b8, c8}), 1);
        if (repulse) begin
            while (cyc < sc + 10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (abort) begin
            while (cyc < sc + 20) @(negedge clk);
            check("busy_before_reset", int'(busy8), 1);
            #1 rst = 1'b1;
            #1 check_all_zero("mid_run_reset");
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (12) @(negedge clk);
            check("idle_after_reset_busy", int'(busy8 | busy2), 0);
            check("idle_after_reset_pat", int'({a8, b8, c8}), 0);
            check("idle_after_reset_done", int'(done8 | done2), 0);
            return;
        end
        n = 0;
        while (!(done8 && done2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("run_timeout", 1, 0);
        repeat (2) @(negedge clk);
        check("done_held", int'(done8 & done2), 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        nand_mask = 8'h00;
        not_mask  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_without_start", int'(busy8 | done8), 0);

        run(8'h00, 8'h00, 1'b0, 1'b0);   // healthy gate
        run(8'h3F, 8'h00, 1'b0, 1'b0);   // nand stuck at 0
        run(8'h00, 8'hAA, 1'b0, 1'b0);   // not stuck at 1
        run(8'h80, 8'h00, 1'b0, 1'b0);   // only the final pattern fails
        for (int i = 0; i < 8; i++) begin
            logic [7:0] nm;
            logic [7:0] tm;
            nm = 8'($urandom_range(0, 255));
            tm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            run(nm, tm, 1'b0, 1'b0);
        end
        run(8'h00, 8'h00, 1'b1, 1'b0);   // start re-pulsed while busy
        run(8'hFF, 8'h00, 1'b0, 1'b1);   // reset mid-run
        run(8'h00, 8'h00, 1'b0, 1'b0);   // clean run after reset

        repeat (5) @(negedge clk);
        check("scoreboard_drained8", q8.size(), 0);
        check("scoreboard_drained2", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
